hwag_sync_ctrl: RTL and testbench

Crank-sync supervisor for the hardware angle generator. It sequences the capture datapath through arm → gap search → synchronised operation. While synchronised it checks every tooth edge for gap consistency. On overflow or repeated gap errors it drops capture, waits a programmable hold-off and re-arms, escalating to a latched fault after too many retries. It sits between the host register file and the capture/TCNT datapath, and its `cape` output replaces the host-driven capture-enable bit.

---
 rtl/hwag_sync_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_hwag_sync_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_sync_ctrl.sv
// Crank-sync supervisor: sequences capture through ARM -> SEARCH -> SYNC and
// recovers via HOLDOFF. Define HWAG_SYNC_CTRL_RETRY_EN to enable retry counting and FAULT escalation.
module hwag_sync_ctrl #(
    parameter int ARM_EDGES = 3,
    parameter int HOLD_W    = 16,
    parameter int ERR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vr_edge,
    input  logic              pcnt_ovf,
    input  logic              hwag_start,
    input  logic              gap_point,
    input  logic              gap_found,
    input  logic [7:0]        thnb,
    input  logic [ERR_W-1:0]  max_err,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [3:0]        max_retry,
    output logic              cape,
    output logic              synced,
    output logic              fault,
    output logic              sync_lost_if,
    output logic [2:0]        state,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [3:0]        retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_SYNC    = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [9:0] ARM_LIMIT = 10'(ARM_EDGES);

    state_t            state_q, state_d;
    logic [8:0]        edge_cnt_q, edge_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              cape_q, cape_d;
    logic              synced_q, synced_d;
    logic              lost_q, lost_d;
    logic              hs_prev_q;
    logic              retry_done;

    logic [9:0]        edge_inc;
    logic [9:0]        search_limit;
    logic [ERR_W-1:0]  err_inc;
    logic [ERR_W-1:0]  eff_max_err;
    logic              hs_fall;

    // Edge counter compared in 10 bits so 2*255+2 remains reachable.
    assign edge_inc     = {1'b0, edge_cnt_q} + 10'd1;
    assign search_limit = {1'b0, thnb, 1'b0} + 10'd2;
    assign err_inc      = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    assign eff_max_err  = (max_err == '0) ? ERR_W'(1) : max_err;
    assign hs_fall      = hs_prev_q & ~hwag_start;

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        err_cnt_d  = err_cnt_q;
        hold_cnt_d = hold_cnt_q;
        lost_d     = 1'b0;

        if (!enable) begin
            state_d    = ST_IDLE;
            edge_cnt_d = '0;
            err_cnt_d  = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;

                ST_ARM: begin
                    if (pcnt_ovf) begin
                        state_d = ST_HOLDOFF;
                    end else if (vr_edge) begin
                        edge_cnt_d = edge_inc[8:0];
                        if (edge_inc >= ARM_LIMIT) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end

                ST_SEARCH: begin
                    if (pcnt_ovf) begin
                        state_d = ST_HOLDOFF;
                    end else if (hwag_start) begin
                        state_d = ST_SYNC;
                    end else if (vr_edge) begin
                        edge_cnt_d = edge_inc[8:0];
                        if (edge_inc >= search_limit) begin
                            state_d = ST_HOLDOFF;
                        end
                    end
                end

                ST_SYNC: begin
                    if (pcnt_ovf) begin
                        state_d = ST_HOLDOFF;
                        lost_d  = 1'b1;
                    end else begin
                        if (vr_edge) begin
                            if (gap_point != gap_found) begin
                                err_cnt_d = err_inc;
                                if (err_inc >= eff_max_err) begin
                                    state_d = ST_HOLDOFF;
                                    lost_d  = 1'b1;
                                end
                            end else if (gap_point) begin
                                err_cnt_d = '0;
                            end
                        end
                        if (hs_fall) begin
                            state_d = ST_HOLDOFF;
                            lost_d  = 1'b1;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    if (hold_cnt_q == '0) begin
                        state_d = retry_done ? ST_FAULT : ST_ARM;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end

                ST_FAULT: state_d = ST_FAULT;

                default: state_d = ST_IDLE;
            endcase
        end

        // Entry actions shared by every transition into a state.
        if (state_d != state_q) begin
            edge_cnt_d = '0;
            if (state_d == ST_HOLDOFF) begin
                hold_cnt_d = holdoff;
            end
            if (state_d == ST_SYNC) begin
                err_cnt_d = '0;
            end
        end

        cape_d   = (state_d == ST_ARM) || (state_d == ST_SEARCH) || (state_d == ST_SYNC);
        synced_d = (state_d == ST_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            err_cnt_q  <= '0;
            hold_cnt_q <= '0;
            cape_q     <= 1'b0;
            synced_q   <= 1'b0;
            lost_q     <= 1'b0;
            hs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            err_cnt_q  <= err_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cape_q     <= cape_d;
            synced_q   <= synced_d;
            lost_q     <= lost_d;
            hs_prev_q  <= hwag_start;
        end
    end

`ifdef HWAG_SYNC_CTRL_RETRY_EN
    logic [3:0] retry_cnt_q, retry_cnt_d;
    logic       fault_q, fault_d;

    assign retry_done = (max_retry != 4'd0) && (retry_cnt_q == max_retry);

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        fault_d     = (state_d == ST_FAULT);
        if (state_d == ST_IDLE) begin
            retry_cnt_d = '0;
        end else if (state_d != state_q) begin
            if (state_d == ST_SYNC) begin
                retry_cnt_d = '0;
            end else if ((state_d == ST_HOLDOFF) && (retry_cnt_q != 4'hF)) begin
                retry_cnt_d = retry_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            fault_q     <= fault_d;
        end
    end

    assign retry_cnt = retry_cnt_q;
    assign fault     = fault_q;
`else
    logic unused_max_retry;

    assign unused_max_retry = ^max_retry;
    assign retry_done       = 1'b0;
    assign retry_cnt        = 4'd0;
    assign fault            = 1'b0;
`endif

    assign state        = state_q;
    assign cape         = cape_q;
    assign synced       = synced_q;
    assign sync_lost_if = lost_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Self-checking bench for hwag_sync_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural supervisor model.
module tb_hwag_sync_ctrl;

`ifdef HWAG_SYNC_CTRL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, enable, vr_edge, pcnt_ovf, hwag_start, gap_point, gap_found;
    logic [7:0]  thnb;
    logic [3:0]  max_err;
    logic [15:0] holdoff;
    logic [3:0]  max_retry;
    logic        cape, synced, fault, sync_lost_if;
    logic [2:0]  state;
    logic [3:0]  err_cnt, retry_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 IDLE, 1 ARM, 2 SEARCH, 3 SYNC, 4 HOLDOFF, 5 FAULT
    int m_state = 0, m_edges = 0, m_err = 0, m_retry = 0, m_hold = 0;
    bit m_lost = 0, m_prev_hs = 0;

    always #5 clk = ~clk;

    hwag_sync_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .vr_edge(vr_edge), .pcnt_ovf(pcnt_ovf),
        .hwag_start(hwag_start), .gap_point(gap_point), .gap_found(gap_found),
        .thnb(thnb), .max_err(max_err), .holdoff(holdoff), .max_retry(max_retry),
        .cape(cape), .synced(synced), .fault(fault), .sync_lost_if(sync_lost_if),
        .state(state), .err_cnt(err_cnt), .retry_cnt(retry_cnt)
    );

    wire [14:0] act_vec = {state, cape, synced, fault, sync_lost_if, err_cnt, retry_cnt};

    function automatic logic [14:0] exp_vec();
        logic [3:0] r;
        r = RETRY_EN ? 4'(m_retry) : 4'd0;
        return {3'(m_state), (m_state >= 1 && m_state <= 3), (m_state == 3),
                (m_state == 5), m_lost, 4'(m_err), r};
    endfunction

    // One clock of the supervisor, applied to the inputs currently driven.
    task automatic model_clk();
        int ns;
        bit lost;
        int eff;
        ns   = m_state;
        lost = 0;
        eff  = (max_err == 0) ? 1 : int'(max_err);
        if (rst) begin
            m_state = 0; m_edges = 0; m_err = 0; m_retry = 0; m_hold = 0;
            m_lost = 0; m_prev_hs = 0;
            return;
        end
        if (!enable) begin
            ns = 0; m_edges = 0; m_err = 0; m_retry = 0; m_hold = 0;
        end else begin
            case (m_state)
                0: ns = 1;
                1: if (pcnt_ovf) ns = 4;
                   else if (vr_edge) begin
                       m_edges++;
                       if (m_edges >= 3) ns = 2;
                   end
                2: if (pcnt_ovf) ns = 4;
                   else if (hwag_start) ns = 3;
                   else if (vr_edge) begin
                       m_edges++;
                       if (m_edges >= 2 * int'(thnb) + 2) ns = 4;
                   end
                3: if (pcnt_ovf) begin ns = 4; lost = 1; end
                   else begin
                       if (vr_edge) begin
                           if (gap_point != gap_found) begin
                               if (m_err < 15) m_err++;
                               if (m_err >= eff) begin ns = 4; lost = 1; end
                           end else if (gap_point) m_err = 0;
                       end
                       if (m_prev_hs && !hwag_start) begin ns = 4; lost = 1; end
                   end
                4: if (m_hold == 0)
                       ns = (RETRY_EN && max_retry != 0 && m_retry == int'(max_retry)) ? 5 : 1;
                   else m_hold--;
                default: ns = m_state;
            endcase
        end
        if (ns != m_state) begin
            m_edges = 0;
            if (ns == 4) begin
                m_hold = int'(holdoff);
                if (m_retry < 15) m_retry++;
            end
            if (ns == 3) begin m_err = 0; m_retry = 0; end
        end
        m_lost    = lost;
        m_prev_hs = hwag_start;
        m_state   = ns;
    endtask

    task automatic tick();
        model_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic acquire();
        enable = 1; hwag_start = 0; vr_edge = 0; pcnt_ovf = 0; gap_point = 0; gap_found = 0;
        for (int i = 0; i < 60 && m_state != 2; i++) begin
            vr_edge = (m_state == 1);
            tick();
        end
        vr_edge = 0;
        hwag_start = 1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            enable = 1'($urandom); vr_edge = 1'($urandom); pcnt_ovf = 1'($urandom);
            tick();
            n_checks++;
            if (act_vec !== exp_vec() || act_vec !== 15'd0) begin
                n_errors++;
                $display("FAIL reset: got %h want %h", act_vec, exp_vec());
            end
        end
        rst = 0; enable = 0; vr_edge = 0; pcnt_ovf = 0;
        tick();
    endtask

    task automatic test_acquisition();
        thnb = 8'd58; enable = 1;
        tick();
        n_checks++;
        if (act_vec !== exp_vec() || state !== 3'd1 || cape !== 1'b1) begin
            n_errors++;
            $display("FAIL acq_arm: got %h want %h", act_vec, exp_vec());
        end
        for (int e = 1; e <= 6; e++) begin
            vr_edge = 1; hwag_start = (e >= 5);
            tick();
            vr_edge = 0;
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL acq_edge%0d: got %h want %h", e, act_vec, exp_vec());
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL acq_gap%0d: got %h want %h", e, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (state !== 3'd3 || synced !== 1'b1) begin
            n_errors++;
            $display("FAIL acq_final: got state=%0d synced=%0d want 3/1", state, synced);
        end
    endtask

    task automatic test_gap_errors();
        logic [1:0] pat [4];
        pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b01;
        max_err = 4'd2;
        for (int k = 0; k < 4; k++) begin
            vr_edge = 1; gap_point = pat[k][1]; gap_found = pat[k][0];
            tick();
            vr_edge = 0;
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL gap_edge%0d: got %h want %h", k, act_vec, exp_vec());
            end
            if (k < 3) begin
                tick();
                n_checks++;
                if (act_vec !== exp_vec() || state !== 3'd3) begin
                    n_errors++;
                    $display("FAIL gap_hold%0d: got %h want %h", k, act_vec, exp_vec());
                end
            end
        end
        n_checks++;
        if (state !== 3'd4 || sync_lost_if !== 1'b1 || cape !== 1'b0 || err_cnt !== 4'd2) begin
            n_errors++;
            $display("FAIL gap_loss: got st=%0d lost=%0d cape=%0d err=%0d want 4/1/0/2",
                     state, sync_lost_if, cape, err_cnt);
        end
        hwag_start = 0; gap_point = 0; gap_found = 0;
        tick();
        n_checks++;
        if (act_vec !== exp_vec() || sync_lost_if !== 1'b0 || state !== 3'd4) begin
            n_errors++;
            $display("FAIL gap_hsfall: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_overflow();
        acquire();
        vr_edge = 1; gap_point = 0; gap_found = 1;
        tick();
        n_checks++;
        if (act_vec !== exp_vec() || err_cnt !== 4'd1) begin
            n_errors++;
            $display("FAIL ovf_pre: got %h want %h", act_vec, exp_vec());
        end
        pcnt_ovf = 1;
        tick();
        pcnt_ovf = 0; vr_edge = 0;
        n_checks++;
        if (act_vec !== exp_vec() || state !== 3'd4 || sync_lost_if !== 1'b1 || err_cnt !== 4'd1) begin
            n_errors++;
            $display("FAIL ovf_loss: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_retry();
        int run, n_hold;
        enable = 0; hwag_start = 0; vr_edge = 0; gap_point = 0; gap_found = 0;
        tick();
        holdoff = 16'd10; max_retry = 4'd2; thnb = 8'd4; enable = 1;
        run = 0; n_hold = 0;
        for (int c = 0; c < 120; c++) begin
            vr_edge = (c % 2 == 0);
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL retry_cyc%0d: got %h want %h", c, act_vec, exp_vec());
            end
            if (state == 3'd4) run++;
            else if (run > 0) begin
                n_checks++;
                if (run != 11) begin
                    n_errors++;
                    $display("FAIL retry_holdlen: got %0d want 11", run);
                end
                n_hold++;
                run = 0;
            end
        end
        vr_edge = 0;
        n_checks++;
        if (n_hold < 2 || fault !== RETRY_EN || (state == 3'd5) !== RETRY_EN) begin
            n_errors++;
            $display("FAIL retry_end: got holds=%0d fault=%0d state=%0d want fault=%0d",
                     n_hold, fault, state, RETRY_EN);
        end
        enable = 0;
        tick();
        n_checks++;
        if (act_vec !== exp_vec() || act_vec !== 15'd0) begin
            n_errors++;
            $display("FAIL retry_disable: got %h want 0", act_vec);
        end
    endtask

    task automatic test_disable_mid_sync();
        thnb = 8'd58; holdoff = 16'd3;
        acquire();
        enable = 0; pcnt_ovf = 1;
        tick();
        pcnt_ovf = 0;
        n_checks++;
        if (act_vec !== exp_vec() || state !== 3'd0 || sync_lost_if !== 1'b0) begin
            n_errors++;
            $display("FAIL dis_ovf: got %h want %h", act_vec, exp_vec());
        end
        acquire();
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (act_vec !== exp_vec() || act_vec !== 15'd0) begin
            n_errors++;
            $display("FAIL rst_sync: got %h want 0", act_vec);
        end
    endtask

    task automatic test_random();
        max_err = 4'($urandom_range(0, 3));
        holdoff = 16'($urandom_range(0, 5));
        max_retry = 4'($urandom_range(0, 3));
        thnb = 8'($urandom_range(2, 8));
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                max_err = 4'($urandom_range(0, 3));
                holdoff = 16'($urandom_range(0, 5));
                max_retry = 4'($urandom_range(0, 3));
                thnb = 8'($urandom_range(2, 8));
            end
            rst        = ($urandom_range(0, 999) == 0);
            enable     = ($urandom_range(0, 149) != 0);
            vr_edge    = ($urandom_range(0, 2) == 0);
            pcnt_ovf   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) hwag_start = ~hwag_start;
            gap_point  = ($urandom_range(0, 3) == 0);
            gap_found  = gap_point ^ ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_cyc%0d: got %h want %h", c, act_vec, exp_vec());
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; enable = 0; vr_edge = 0; pcnt_ovf = 0; hwag_start = 0;
        gap_point = 0; gap_found = 0; thnb = 8'd58; max_err = 4'd2;
        holdoff = 16'd3; max_retry = 4'd2;
        test_reset();
        test_acquisition();
        test_gap_errors();
        test_overflow();
        test_retry();
        test_disable_mid_sync();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
